// File: rtl/to_upper_pkg.sv
// Shared constants and types for the ASCII (optionally Latin-1) upper-case converter.
package to_upper_pkg;
    typedef logic [7:0] char_t;

    localparam char_t LOWER_A     = 8'h61;
    localparam char_t LOWER_Z     = 8'h7A;
    localparam int    CASE_BIT    = 5;
    localparam char_t L1_LOWER_LO = 8'hE0;
    localparam char_t L1_LOWER_HI = 8'hFE;
    localparam char_t L1_DIVIDE   = 8'hF7;
endpackage

// File: rtl/to_upper_if.sv
// Character bus for to_upper: per-bit input byte and per-bit converted byte.
interface to_upper_if;
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    logic a0_out, a1_out, a2_out, a3_out, a4_out, a5_out, a6_out, a7_out;

    modport master (
        output a0, a1, a2, a3, a4, a5, a6, a7,
        input  a0_out, a1_out, a2_out, a3_out, a4_out, a5_out, a6_out, a7_out
    );
    modport slave (
        input  a0, a1, a2, a3, a4, a5, a6, a7,
        output a0_out, a1_out, a2_out, a3_out, a4_out, a5_out, a6_out, a7_out
    );
endinterface

// File: rtl/to_upper_detect.sv
// Lowercase detector. Latin-1 lowercase (E0..FE except F7) is included
// only when TO_UPPER_LATIN1_EN is defined.
module to_upper_detect
    import to_upper_pkg::*;
(
    input  char_t ch,
    output logic  is_lower
);
    logic ascii_lower;
    logic latin_lower;

    assign ascii_lower = (ch >= LOWER_A) && (ch <= LOWER_Z);

`ifdef TO_UPPER_LATIN1_EN
    assign latin_lower = (ch >= L1_LOWER_LO) && (ch <= L1_LOWER_HI) && (ch != L1_DIVIDE);
`else
    assign latin_lower = 1'b0;
`endif

    assign is_lower = ascii_lower | latin_lower;
endmodule

// File: rtl/to_upper.sv
// Registered byte case converter, one cycle latency, one byte per cycle.
// Optional Latin-1 support via TO_UPPER_LATIN1_EN.
module to_upper
    import to_upper_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic a5,
    input  logic a6,
    input  logic a7,
    output logic a0_out,
    output logic a1_out,
    output logic a2_out,
    output logic a3_out,
    output logic a4_out,
    output logic a5_out,
    output logic a6_out,
    output logic a7_out
);
    char_t ch;
    char_t nxt;
    char_t q;
    logic  is_lower;

    assign ch = {a7, a6, a5, a4, a3, a2, a1, a0};

    to_upper_detect u_detect (
        .ch       (ch),
        .is_lower (is_lower)
    );

    // Upper and lower case differ only in the case bit, so conversion is a single-bit clear.
    always_comb begin
        nxt           = ch;
        nxt[CASE_BIT] = ch[CASE_BIT] & ~is_lower;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= nxt;
    end

    assign {a7_out, a6_out, a5_out, a4_out, a3_out, a2_out, a1_out, a0_out} = q;
endmodule

// File: tb/tb_to_upper.sv
// Scoreboard bench for to_upper: stimulus pushes expected bytes, a monitor pops and compares.
module tb_to_upper;
    import to_upper_pkg::*;

    typedef struct {
        char_t din;
        char_t exp;
    } item_t;

    logic  clk;
    logic  rst_n;
    char_t din;
    char_t dout;
    item_t sb[$];
    int    checks;
    int    errors;

    to_upper_if bus ();

    assign {bus.a7, bus.a6, bus.a5, bus.a4, bus.a3, bus.a2, bus.a1, bus.a0} = din;
    assign dout = {bus.a7_out, bus.a6_out, bus.a5_out, bus.a4_out,
                   bus.a3_out, bus.a2_out, bus.a1_out, bus.a0_out};

    to_upper dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a0     (bus.a0),
        .a1     (bus.a1),
        .a2     (bus.a2),
        .a3     (bus.a3),
        .a4     (bus.a4),
        .a5     (bus.a5),
        .a6     (bus.a6),
        .a7     (bus.a7),
        .a0_out (bus.a0_out),
        .a1_out (bus.a1_out),
        .a2_out (bus.a2_out),
        .a3_out (bus.a3_out),
        .a4_out (bus.a4_out),
        .a5_out (bus.a5_out),
        .a6_out (bus.a6_out),
        .a7_out (bus.a7_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string name, input char_t exp);
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, dout, exp);
        end
    endtask

    // Drive a byte half a cycle before the sampling edge and record its expectation.
    task automatic send(input char_t b, input char_t exp);
        item_t it;
        @(negedge clk);
        din    = b;
        it.din = b;
        it.exp = exp;
        sb.push_back(it);
    endtask

    // Monitor: output is valid every cycle after a byte was issued.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                checks++;
                if (dout !== it.exp) begin
                    errors++;
                    $display("FAIL conv in=%0d: got %0d expected %0d", it.din, dout, it.exp);
                end
            end
        end
    end

    initial begin
        char_t ascii_in  [15] = '{8'd97, 8'd109, 8'd122, 8'd96, 8'd123,
                                  8'd40, 8'd72, 8'd65, 8'd71, 8'd124,
                                  8'd20, 8'd48, 8'd58, 8'd127, 8'd0};
        char_t ascii_exp [15] = '{8'd65, 8'd77, 8'd90, 8'd96, 8'd123,
                                  8'd40, 8'd72, 8'd65, 8'd71, 8'd124,
                                  8'd20, 8'd48, 8'd58, 8'd127, 8'd0};
        char_t high_in   [10] = '{8'd131, 8'd146, 8'd148, 8'd183, 8'd207,
                                  8'd235, 8'd224, 8'd254, 8'd247, 8'd223};
`ifdef TO_UPPER_LATIN1_EN
        char_t high_exp  [10] = '{8'd131, 8'd146, 8'd148, 8'd183, 8'd207,
                                  8'd203, 8'd192, 8'd222, 8'd247, 8'd223};
`else
        char_t high_exp  [10] = '{8'd131, 8'd146, 8'd148, 8'd183, 8'd207,
                                  8'd235, 8'd224, 8'd254, 8'd247, 8'd223};
`endif
        int wait_cnt;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        din    = 8'd97;

        // Reset holds outputs at zero despite clocking a lowercase byte.
        #2 check_now("reset_async", 8'h00);
        repeat (3) @(posedge clk);
        #1 check_now("reset_clocked", 8'h00);

        // Release mid-cycle; the first edge after release loads 'A'.
        @(posedge clk);
        #2 rst_n = 1'b1;
        send(8'd97, 8'd65);

        for (int i = 0; i < 15; i++) send(ascii_in[i], ascii_exp[i]);
        for (int i = 0; i < 10; i++) send(high_in[i], high_exp[i]);

        // Back-to-back lowercase stream.
        send(8'd97, 8'd65);
        send(8'd98, 8'd66);
        send(8'd99, 8'd67);
        send(8'd120, 8'd88);

        // Mid-stream reset between edges: clears with no clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1 check_now("reset_midstream", 8'h00);
        @(posedge clk);
        #1 check_now("reset_midstream_hold", 8'h00);
        #1 rst_n = 1'b1;
        send(8'd122, 8'd90);
        send(8'd255, 8'd255);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d items left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
